// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths, operand classes,
// exponent bias and the canonical quiet-NaN pattern.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int FP_MAX_W  = 128;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Wide result; callers cast down to their own word width.
    function automatic logic [FP_MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP multiplier.
interface fp_mult_pipe_if
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         flag_invalid;
    logic         flag_overflow;
    logic         flag_underflow;
    logic         flag_inexact;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out,
        input  flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out,
        output flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );

endinterface

// File: rtl/fp_round_pack.sv
// Combinational normalise, round-to-nearest-even, range check and pack for
// a raw mantissa product plus biased exponent sum.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                          sign,
    input  logic                          special,
    input  logic                          invalid,
    input  logic [EXP_W+MAN_W:0]          special_val,
    input  logic [2*(MAN_W+1)-1:0]        prod,
    input  logic signed [EXP_W+1:0]       exp_sum,
    output logic [EXP_W+MAN_W:0]          res,
    output logic                          flag_invalid,
    output logic                          flag_overflow,
    output logic                          flag_underflow,
    output logic                          flag_inexact
);
    localparam int P  = 2 * (MAN_W + 1);
    localparam int E2 = EXP_W + 2;
    localparam logic signed [E2-1:0] EXP_MAX = E2'((1 << EXP_W) - 1);

    logic                 msb;
    logic [MAN_W-1:0]     frac;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [MAN_W:0]       frac_r;
    logic signed [E2-1:0] exp_adj;
    logic signed [E2-1:0] exp_fin;

    always_comb begin
        msb = prod[P-1];
        // Without the top bit set the field windows sit one position lower,
        // equivalent to shifting the product left by one.
        if (msb) begin
            frac   = prod[P-2 -: MAN_W];
            guard  = prod[P-2-MAN_W];
            sticky = |prod[P-3-MAN_W:0];
        end else begin
            frac   = prod[P-3 -: MAN_W];
            guard  = prod[P-3-MAN_W];
            sticky = |prod[P-4-MAN_W:0];
        end

        round_up = guard & (sticky | frac[0]);
        frac_r   = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        exp_adj  = exp_sum + $signed({{(E2-1){1'b0}}, msb});
        exp_fin  = exp_adj + $signed({{(E2-1){1'b0}}, frac_r[MAN_W]});

        res            = {sign, exp_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
        flag_invalid   = 1'b0;
        flag_overflow  = 1'b0;
        flag_underflow = 1'b0;
        flag_inexact   = guard | sticky;

        if (special) begin
            res          = special_val;
            flag_invalid = invalid;
            flag_inexact = 1'b0;
        end else if (exp_fin >= EXP_MAX) begin
            res           = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flag_overflow = 1'b1;
            flag_inexact  = 1'b1;
        end else if (exp_fin[E2-1] || (exp_fin == '0)) begin
            res            = {sign, {(EXP_W+MAN_W){1'b0}}};
            flag_underflow = 1'b1;
            flag_inexact   = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier: classify, multiply,
// round/pack, with one global stall enable driven by the output handshake.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_mult_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M1 = MAN_W + 1;
    localparam int P  = 2 * M1;
    localparam int E2 = EXP_W + 2;
    localparam logic signed [E2-1:0] BIAS    = E2'(fp_bias(EXP_W));
    localparam logic [W-1:0]         NAN_VAL = W'(canon_nan(EXP_W, MAN_W));

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) return ZERO;
        if (e == '1) return (f == '0) ? INF : NAN;
        return NORM;
    endfunction

    logic en;

    // Stage 1 registers
    logic             s1_valid_reg;
    logic             s1_sign_reg;
    fp_class_t        s1_cls_a_reg;
    fp_class_t        s1_cls_b_reg;
    logic [EXP_W-1:0] s1_exp_a_reg;
    logic [EXP_W-1:0] s1_exp_b_reg;
    logic [M1-1:0]    s1_man_a_reg;
    logic [M1-1:0]    s1_man_b_reg;

    // Stage 2 registers
    logic                 s2_valid_reg;
    logic                 s2_sign_reg;
    logic                 s2_special_reg;
    logic                 s2_invalid_reg;
    logic [W-1:0]         s2_special_val_reg;
    logic [P-1:0]         s2_prod_reg;
    logic signed [E2-1:0] s2_exp_reg;

    // Stage 3 (output) registers
    logic         out_valid_reg;
    logic [W-1:0] out_reg;
    logic         flag_invalid_reg;
    logic         flag_overflow_reg;
    logic         flag_underflow_reg;
    logic         flag_inexact_reg;

    logic         any_nan;
    logic         any_inf;
    logic         any_zero;
    logic [W-1:0] special_val;

    logic [W-1:0] rp_res;
    logic         rp_invalid;
    logic         rp_overflow;
    logic         rp_underflow;
    logic         rp_inexact;

    assign en           = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
        end else if (en) begin
            s1_valid_reg <= bus.in_valid;
            s1_sign_reg  <= bus.a[W-1] ^ bus.b[W-1];
            s1_cls_a_reg <= classify(bus.a[W-2 -: EXP_W], bus.a[MAN_W-1:0]);
            s1_cls_b_reg <= classify(bus.b[W-2 -: EXP_W], bus.b[MAN_W-1:0]);
            s1_exp_a_reg <= bus.a[W-2 -: EXP_W];
            s1_exp_b_reg <= bus.b[W-2 -: EXP_W];
            s1_man_a_reg <= {1'b1, bus.a[MAN_W-1:0]};
            s1_man_b_reg <= {1'b1, bus.b[MAN_W-1:0]};
        end
    end

    // NaN outranks inf, which outranks zero; inf x zero is itself invalid.
    always_comb begin
        any_nan  = (s1_cls_a_reg == NAN) || (s1_cls_b_reg == NAN) ||
                   ((s1_cls_a_reg == INF) && (s1_cls_b_reg == ZERO)) ||
                   ((s1_cls_a_reg == ZERO) && (s1_cls_b_reg == INF));
        any_inf  = (s1_cls_a_reg == INF) || (s1_cls_b_reg == INF);
        any_zero = (s1_cls_a_reg == ZERO) || (s1_cls_b_reg == ZERO);
        if (any_nan) begin
            special_val = NAN_VAL;
        end else if (any_inf) begin
            special_val = {s1_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            special_val = {s1_sign_reg, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
        end else if (en) begin
            s2_valid_reg       <= s1_valid_reg;
            s2_sign_reg        <= s1_sign_reg;
            s2_special_reg     <= any_nan || any_inf || any_zero;
            s2_invalid_reg     <= any_nan;
            s2_special_val_reg <= special_val;
            s2_prod_reg        <= P'(s1_man_a_reg) * P'(s1_man_b_reg);
            s2_exp_reg         <= $signed({2'b00, s1_exp_a_reg}) + $signed({2'b00, s1_exp_b_reg}) - BIAS;
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign           (s2_sign_reg),
        .special        (s2_special_reg),
        .invalid        (s2_invalid_reg),
        .special_val    (s2_special_val_reg),
        .prod           (s2_prod_reg),
        .exp_sum        (s2_exp_reg),
        .res            (rp_res),
        .flag_invalid   (rp_invalid),
        .flag_overflow  (rp_overflow),
        .flag_underflow (rp_underflow),
        .flag_inexact   (rp_inexact)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg      <= 1'b0;
            out_reg            <= '0;
            flag_invalid_reg   <= 1'b0;
            flag_overflow_reg  <= 1'b0;
            flag_underflow_reg <= 1'b0;
            flag_inexact_reg   <= 1'b0;
        end else if (en) begin
            out_valid_reg      <= s2_valid_reg;
            out_reg            <= rp_res;
            flag_invalid_reg   <= rp_invalid;
            flag_overflow_reg  <= rp_overflow;
            flag_underflow_reg <= rp_underflow;
            flag_inexact_reg   <= rp_inexact;
        end
    end

    assign bus.out_valid      = out_valid_reg;
    assign bus.out            = out_reg;
    assign bus.flag_invalid   = flag_invalid_reg;
    assign bus.flag_overflow  = flag_overflow_reg;
    assign bus.flag_underflow = flag_underflow_reg;
    assign bus.flag_inexact   = flag_inexact_reg;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe: driver queues hand-computed results,
// a negedge monitor pops and compares every accepted output.
module tb_fp_mult_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_mult_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] val;
        logic [3:0]  flg;   // {invalid, overflow, underflow, inexact}
        bit          chk_lat;
        int          due;
        string       name;
    } exp_t;

    exp_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    function automatic logic [3:0] dut_flags();
        return {bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic [3:0] f, input string name, input bit lat);
        exp_t e;
        int   waited;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        waited       = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.in_ready && waited < 50);
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL %s_accept: actual=in_ready stuck low required=accept within 50 cycles", name);
        end else begin
            e.val = r; e.flg = f; e.chk_lat = lat; e.due = cyc + 3; e.name = name;
            exp_q.push_back(e);
            $display("issue %s: a=%h b=%h expect=%h flags=%b", name, a, b, r, f);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s_drain: actual=%0d pending required=0 pending", name, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: compare accepted outputs, hold-stability during stalls.
    logic        stall_prev = 1'b0;
    logic [31:0] held_out;
    logic [3:0]  held_flg;
    exp_t        m_e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) begin
                    check("stall_hold_valid", {31'b0, bus.out_valid}, 32'd1);
                    check("stall_hold_out", bus.out, held_out);
                    check("stall_hold_flags", {28'b0, dut_flags()}, {28'b0, held_flg});
                end
                if (bus.out_valid && !bus.out_ready)
                    check("in_ready_stalled", {31'b0, bus.in_ready}, 32'd0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: actual=%h required=no output", bus.out);
                    end else begin
                        m_e = exp_q.pop_front();
                        $display("result %s: out=%h flags=%b", m_e.name, bus.out, dut_flags());
                        check({m_e.name, "_out"}, bus.out, m_e.val);
                        check({m_e.name, "_flags"}, {28'b0, dut_flags()}, {28'b0, m_e.flg});
                        if (m_e.chk_lat)
                            check({m_e.name, "_latency"}, 32'(cyc), 32'(m_e.due));
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held_out   = bus.out;
                held_flg   = dut_flags();
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    logic [31:0] va [15] = '{32'h3F800000, 32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h7F7FFFFF,
                             32'h00800000, 32'h40000000, 32'hC0000000, 32'h7FC00000, 32'h80000000,
                             32'h00000001, 32'h3F800001, 32'h3FB510AB, 32'h00800000, 32'h00000000};
    logic [31:0] vb [15] = '{32'h3F800000, 32'h3F800001, 32'h00000000, 32'h40000000, 32'h40000000,
                             32'h3F000000, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h3F800001, 32'h3FB4F93C, 32'h3F800000, 32'hFF800000};
    logic [31:0] vr [15] = '{32'h3F800000, 32'h3FC00002, 32'h7FC00000, 32'hFF800000, 32'h7F800000,
                             32'h00000000, 32'h40C00000, 32'hC0000000, 32'h7FC00000, 32'h80000000,
                             32'h00000000, 32'h3F800002, 32'h40000000, 32'h00800000, 32'h7FC00000};
    logic [3:0]  vf [15] = '{4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0101,
                             4'b0011, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
                             4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b1000};

    logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] bp_r [6] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_out", bus.out, 32'h0);
        check("reset_flags", {28'b0, dut_flags()}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;

        // Isolated first product so its latency is measured on an idle pipe.
        send(va[0], vb[0], vr[0], vf[0], "v0", 1'b1);
        drain("v0");
        for (int i = 1; i < 15; i++)
            send(va[i], vb[i], vr[i], vf[i], $sformatf("v%0d", i), 1'b0);
        drain("directed");

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(bp_a[i], 32'h40000000, bp_r[i], 4'b0000, $sformatf("bp%0d", i), 1'b0);
            end
            begin
                repeat (3) @(posedge clk); #1;
                bus.out_ready = 1'b0;
                repeat (5) @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("backpressure");

        // Fill all three stages while stalled, then reset over them.
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, "rs0", 1'b0);
        send(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, "rs1", 1'b0);
        send(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, "rs2", 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        send(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, "post_reset", 1'b0);
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_mult_pipe.md
FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, stored fraction width; W = 1+EXP_W+MAN_W (32 by default).
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, operand pair a/b is valid.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts a/b this cycle.
REQ-007 The block SHALL have ports a and b, input, W each, IEEE-style operands {sign, exponent, fraction}.
REQ-008 The block SHALL have port out_valid, output, 1, result is valid.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 The block SHALL have port out, output, W, product.
REQ-011 The block SHALL have ports flag_invalid, flag_overflow, flag_underflow and flag_inexact, output, 1 each, qualified by out_valid.

Function
REQ-012 Pipeline SHALL be 3 stages: S1 unpack and classify; S2 mantissa multiply, (MAN_W+1)x(MAN_W+1) to 2*(MAN_W+1) bits; S3 normalise, round, pack.
REQ-013 Global advance SHALL be en = !out_valid || out_ready; in_ready = en; a transfer occurs when in_valid && in_ready.
REQ-014 With out_ready held high, latency SHALL be 3 cycles from input transfer to out_valid, at a throughput of one result per cycle.
REQ-015 When en is low, every stage SHALL hold; out, the flags and out_valid stay stable until accepted; no result is lost or duplicated.
REQ-016 Classification SHALL use exp==0 as ZERO (subnormal inputs flushed to zero), exp==all-ones with frac==0 as INF, exp==all-ones with frac!=0 as NAN, and anything else as NORM with hidden bit 1.
REQ-017 Special-case priority SHALL be: any NAN, or INF x ZERO -> canonical NaN (sign 0, exp all-ones, frac MSB 1, rest 0) with flag_invalid=1; else INF -> inf with sign sA^sB; else ZERO -> zero with sign sA^sB.
REQ-018 For NORM x NORM, the exponent SHALL be computed signed in EXP_W+2 bits as eA+eB-BIAS, BIAS = 2^(EXP_W-1)-1, plus 1 if the product MSB is set (the product is shifted left 1 otherwise).
REQ-019 Rounding SHALL be round-to-nearest-even using guard bit G and sticky S (OR of the remaining bits): increment if G && (S || lsb); flag_inexact = G||S.
REQ-020 A rounding carry-out SHALL set the fraction to 0 and increment the exponent, and the overflow check SHALL follow this increment.
REQ-021 A final exponent >= 2^EXP_W-1 SHALL give signed inf, flag_overflow=1, flag_inexact=1.
REQ-022 A final exponent <= 0 SHALL give signed zero, flag_underflow=1, flag_inexact=1 (no subnormal output).
REQ-023 Flags SHALL be 0 whenever their condition is absent; flags SHALL travel with their result through the pipeline.

Reset
REQ-024 While rst_n=0 at a clock edge, all stage valid bits SHALL clear, out_valid=0, out=0, and all flags=0.
REQ-025 A reset asserted mid-operation SHALL discard all in-flight operands; the first result after reset SHALL come from the first post-reset transfer.
REQ-026 in_ready SHALL equal 1 in the cycle after reset is released.

Structure
REQ-027 Package fp_pkg SHALL hold the EXP_W/MAN_W defaults, the class enum {ZERO, NORM, INF, NAN}, a bias function, and a canonical-NaN constant function.
REQ-028 S3 SHALL be a sub-module fp_round_pack (normalise, RNE, overflow/underflow, pack), combinational, with the S3 register kept in fp_mult_pipe.
REQ-029 Datapath widths SHALL derive only from EXP_W/MAN_W; there SHALL be no hard-coded 8/23/32.

Verification
REQ-030 0x3F800000 x 0x3F800000 with out_ready=1 -> out=0x3F800000 with out_valid exactly 3 cycles after transfer and all flags 0.
REQ-031 0x3FC00000 x 0x3F800001 (exact tie, odd lsb) -> 0x3FC00002 with flag_inexact=1.
REQ-032 0x7F800000 x 0x00000000 -> 0x7FC00000 with flag_invalid=1; 0xFF800000 x 0x40000000 -> 0xFF800000 with no flags.
REQ-033 0x7F7FFFFF x 0x40000000 -> 0x7F800000 with flag_overflow=1; 0x00800000 x 0x3F000000 -> 0x00000000 with flag_underflow=1.
REQ-034 Backpressure: stream 6 back-to-back products with out_ready low for 5 cycles mid-stream -> in_ready low while stalled, and all 6 results arrive in order with values held stable during the stall.
REQ-035 Reset mid-operation: assert rst_n=0 for one cycle with 3 products in flight -> out_valid=0 next cycle and no stale result ever appears.
